// File: rtl/cpu_pkg.sv
// Shared CPU definitions: exception codes, control NOP encoding and the
// default datapath widths used by pipeline stage registers.
package cpu_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 30;
  localparam int unsigned CTRL_W_DEF = 12;
  localparam int unsigned EXP_W_DEF  = 3;
  localparam int unsigned NSRC_DEF   = 4;

  // Exception codes; zero means the beat carries no exception.
  localparam logic [EXP_W_DEF-1:0] EXP_NO_EXP   = 3'd0;
  localparam logic [EXP_W_DEF-1:0] EXP_EXT_INT  = 3'd1;
  localparam logic [EXP_W_DEF-1:0] EXP_OVERFLOW = 3'd2;

  // All-zero control payload: no memory op, no control op, no GPR write.
  localparam int unsigned CTRL_NOP = 0;

endpackage

// File: rtl/ex_pipe_skid.sv
// Two-entry (main + skid) pipeline buffer for one opaque beat.
// in_ready is registered, so there is no combinational path from out_ready.
// Ports:
//   clk, reset_            clock, async active-low reset
//   in_valid/in_ready      upstream handshake, in_beat payload
//   flush                  drop both entries at the next edge
//   out_valid/out_ready    downstream handshake, out_beat payload
module ex_pipe_skid #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset_,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_beat,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_beat
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FULL  = 2'd1,
    S_SKID  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   main_q, main_d;
  logic [W-1:0]   skid_q, skid_d;
  logic           ready_q, ready_d;
  logic           xfer_in_c, xfer_out_c;

  // State and entry registers
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q <= S_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= ready_d;
    end
  end

  // Next-state: main always drains before skid; skid slides into main on pop
  always_comb begin
    state_d    = state_q;
    main_d     = main_q;
    skid_d     = skid_q;
    xfer_in_c  = in_valid & ready_q & ~flush;
    xfer_out_c = (state_q != S_EMPTY) & out_ready;

    if (flush) begin
      state_d = S_EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      unique case (state_q)
        S_EMPTY: begin
          if (xfer_in_c) begin
            state_d = S_FULL;
            main_d  = in_beat;
          end
        end
        S_FULL: begin
          if (xfer_in_c && xfer_out_c) begin
            main_d = in_beat;
          end else if (xfer_in_c) begin
            state_d = S_SKID;
            skid_d  = in_beat;
          end else if (xfer_out_c) begin
            state_d = S_EMPTY;
          end
        end
        S_SKID: begin
          if (xfer_out_c) begin
            state_d = S_FULL;
            main_d  = skid_q;
            skid_d  = '0;
          end
        end
        default: begin
          state_d = S_EMPTY;
        end
      endcase
    end

    // Ready for the next cycle is simply "skid entry will be free"
    ready_d = (state_d != S_SKID);
  end

  assign in_ready  = ready_q;
  assign out_valid = (state_q != S_EMPTY);
  assign out_beat  = main_q;

endmodule

// File: rtl/ex_pipe_reg.sv
// EX/MEM pipeline stage register with exception injection and flush.
// Build macro EX_PIPE_SKID_EN selects a main+skid buffer with registered
// in_ready; otherwise a single entry with in_ready = ~out_valid | out_ready.
// Ports:
//   clk, reset_                          clock, async active-low reset
//   in_valid/in_ready                    upstream handshake
//   in_pc, in_ctrl, in_data, in_wr_data, in_exp   upstream payload
//   exc_req[NSRC], exc_code[NSRC*EXP_W]  injection requests, index 0 wins
//   flush                                discard all buffered beats
//   out_valid/out_ready                  downstream handshake
//   out_pc, out_ctrl, out_data, out_wr_data, out_exp, out_injected  payload
module ex_pipe_reg
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned CTRL_W = CTRL_W_DEF,
  parameter int unsigned EXP_W  = EXP_W_DEF,
  parameter int unsigned NSRC   = NSRC_DEF
) (
  input  logic                  clk,
  input  logic                  reset_,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_W-1:0]     in_pc,
  input  logic [CTRL_W-1:0]     in_ctrl,
  input  logic [DATA_W-1:0]     in_data,
  input  logic [DATA_W-1:0]     in_wr_data,
  input  logic [EXP_W-1:0]      in_exp,
  input  logic [NSRC-1:0]       exc_req,
  input  logic [NSRC*EXP_W-1:0] exc_code,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_W-1:0]     out_pc,
  output logic [CTRL_W-1:0]     out_ctrl,
  output logic [DATA_W-1:0]     out_data,
  output logic [DATA_W-1:0]     out_wr_data,
  output logic [EXP_W-1:0]      out_exp,
  output logic                  out_injected
);

  // Beat layout: {pc, ctrl, data, wr_data, exp, injected}
  localparam int unsigned BEAT_W = ADDR_W + CTRL_W + 2*DATA_W + EXP_W + 1;

  logic              inj_c;
  logic [EXP_W-1:0]  inj_code_c;
  logic [BEAT_W-1:0] in_beat_c;
  logic [BEAT_W-1:0] out_beat;

  // Priority encoder: lowest set request index supplies the code
  always_comb begin
    inj_c      = 1'b0;
    inj_code_c = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (exc_req[i] && !inj_c) begin
        inj_c      = 1'b1;
        inj_code_c = exc_code[i*EXP_W +: EXP_W];
      end
    end
  end

  // An injected exception keeps the PC but turns the beat into a NOP
  always_comb begin
    if (inj_c) begin
      in_beat_c = {in_pc, CTRL_W'(CTRL_NOP), {DATA_W{1'b0}}, {DATA_W{1'b0}},
                   inj_code_c, 1'b1};
    end else begin
      in_beat_c = {in_pc, in_ctrl, in_data, in_wr_data, in_exp, 1'b0};
    end
  end

`ifdef EX_PIPE_SKID_EN

  ex_pipe_skid #(
    .W (BEAT_W)
  ) u_skid (
    .clk       (clk),
    .reset_    (reset_),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_beat   (in_beat_c),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_beat  (out_beat)
  );

`else

  logic              valid_q, valid_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              xfer_in_c;
  logic              xfer_out_c;

  assign in_ready   = ~valid_q | out_ready;
  assign xfer_in_c  = in_valid & in_ready & ~flush;
  assign xfer_out_c = valid_q & out_ready;

  // Next entry: flush wins, then a load (also covers replace-on-pop), then drain
  always_comb begin
    valid_d = valid_q;
    beat_d  = beat_q;
    if (flush) begin
      valid_d = 1'b0;
      beat_d  = '0;
    end else if (xfer_in_c) begin
      valid_d = 1'b1;
      beat_d  = in_beat_c;
    end else if (xfer_out_c) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      valid_q <= 1'b0;
      beat_q  <= '0;
    end else begin
      valid_q <= valid_d;
      beat_q  <= beat_d;
    end
  end

  assign out_valid = valid_q;
  assign out_beat  = beat_q;

`endif

  assign {out_pc, out_ctrl, out_data, out_wr_data, out_exp, out_injected} = out_beat;

endmodule

// File: doc/ex_pipe_reg.md
EX_PIPE_REG -- requirements
Module: ex_pipe_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32, ALU result / store data width.
REQ-002 SHALL have parameter ADDR_W, default 30, word PC width.
REQ-003 SHALL have parameter CTRL_W, default 12, packed control payload width (mem op, ctrl op, dst addr, gpr_we_); all-zero means NOP with no side effects.
REQ-004 SHALL have parameter EXP_W, default 3, exception code width; code 0 means no exception.
REQ-005 SHALL have parameter NSRC, default 4, number of exception-injection sources; index 0 has highest priority.
REQ-006 SHALL have reset reset_, asynchronous, active-low; clock clk.
REQ-007 Ports: clk in 1 clock; reset_ in 1 async active-low reset; in_valid in 1 upstream beat valid; in_ready out 1 accept; in_pc in ADDR_W; in_ctrl in CTRL_W; in_data in DATA_W ALU result; in_wr_data in DATA_W store data; in_exp in EXP_W upstream exception code.
REQ-008 Ports: exc_req in NSRC injection requests; exc_code in NSRC*EXP_W codes, source i at bits [i*EXP_W +: EXP_W]; flush in 1 discard all.
REQ-009 Ports: out_valid out 1; out_ready in 1; out_pc out ADDR_W; out_ctrl out CTRL_W; out_data out DATA_W; out_wr_data out DATA_W; out_exp out EXP_W; out_injected out 1, set when the beat carries an injected exception.

Function
REQ-010 Transfer in occurs when in_valid & in_ready & ~flush; transfer out occurs when out_valid & out_ready.
REQ-011 Latency SHALL be exactly 1 cycle from transfer in to out_valid when the register is empty.
REQ-012 On transfer in with any exc_req bit set, the lowest set index i SHALL win: out_pc = in_pc, out_ctrl = 0, out_data = 0, out_wr_data = 0, out_exp = exc_code[i], out_injected = 1.
REQ-013 On transfer in with no exc_req, the payload SHALL pass unmodified and out_injected = 0; in_exp passes through.
REQ-014 exc_req SHALL be ignored in cycles without a transfer in; no request is remembered.
REQ-015 flush SHALL clear every valid entry at the next edge and override a simultaneous transfer in or out; cleared entries return all payload to 0.
REQ-016 A simultaneous transfer out and transfer in when full SHALL replace the entry, with no bubble.
REQ-017 A held output (out_valid & ~out_ready) SHALL keep every out_* bit stable until transfer out or flush.

Reset
REQ-018 While reset_ is low: out_valid = 0, all payload outputs = 0, out_exp = 0, out_injected = 0, skid entry empty.
REQ-019 Reset asserted mid-transfer SHALL drop the beat; after release, in_ready SHALL be 1 on the first cycle.

Configuration
REQ-020 Macro EX_PIPE_SKID_EN SHALL select buffering mode.
REQ-021 Without EX_PIPE_SKID_EN: single entry; in_ready = ~out_valid | out_ready (combinational from out_ready).
REQ-022 With EX_PIPE_SKID_EN: main entry plus one skid entry; in_ready SHALL be a registered ~skid_valid with no combinational path from out_ready.
REQ-023 With EX_PIPE_SKID_EN, states are EMPTY, FULL and SKID; EMPTY->FULL on in; FULL->SKID on in & ~out; SKID->FULL on out; FULL->EMPTY on out & ~in; any state ->EMPTY on flush.
REQ-024 With EX_PIPE_SKID_EN, order SHALL be preserved: the main entry drains before the skid entry, and the skid entry moves to main on transfer out.

Structure
REQ-025 Shared package cpu_pkg SHALL hold EXP_NO_EXP = 0, EXP_EXT_INT, EXP_OVERFLOW, CTRL_NOP = 0 and the default width constants.
REQ-026 Skid logic SHALL live in sub-module ex_pipe_skid, instantiated only under EX_PIPE_SKID_EN.
REQ-027 The priority encoder over exc_req SHALL be combinational and local to ex_pipe_reg.

Verification
REQ-028 Reset, then in_pc=0x100, in_data=0x5, no exc_req -> next cycle out_valid=1, out_pc=0x100, out_data=0x5, out_exp=0.
REQ-029 exc_req=4'b0110, codes[1]=2, codes[2]=3 with transfer -> out_exp=2, out_ctrl=0, out_data=0, out_injected=1, out_pc kept.
REQ-030 out_ready=0 for 3 cycles with in_valid=1 -> outputs stable; without the macro in_ready=0 after 1 beat; with the macro 2 beats accepted, then in_ready=0.
REQ-031 flush together with in_valid=1 in state SKID -> next cycle out_valid=0, in_ready=1, payload 0; the incoming beat is never emitted.
REQ-032 Back-to-back stream of 8 beats with out_ready toggling 1,0 -> all 8 beats emerge in order with no duplicates or loss.
